prog_loader: RTL and testbench

- Byte-stream program loader for the pipelined CPU; the hardware writer counterpart to the bench-side state dump.
- Accepts framed commands over a valid/ready byte interface and writes 32-bit words into Instruction_Memory and bytes into Data_Memory.
- Holds the CPU idle until a START command, then drives start_i high.
- Sits beside CPU at top level; its write ports mux into the memories while start_o is low.

---
 rtl/prog_loader_pkg.sv | 24 ++
 rtl/prog_loader_shift_asm.sv | 29 ++
 rtl/prog_loader.sv | 168 ++++++++++++++++
 tb/tb_prog_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_loader_pkg;

  // Command byte codes that open a frame.
  localparam logic [7:0] CMD_IWR   = 8'h01;
  localparam logic [7:0] CMD_DWR   = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;

  // Data payload lengths in bytes (address byte not included).
  localparam logic [2:0] IWR_LEN = 3'd4;
  localparam logic [2:0] DWR_LEN = 3'd1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CHK,
    WRITE,
    RUN
  } state_t;

endpackage

// File: rtl/prog_loader_shift_asm.sv
// 8-to-32 MSB-first shift assembler with a byte counter.
// Latency: one cycle; shifted byte and count are visible after the edge.
// Backpressure: none; the caller decides when to shift or clear.
// Ports: clk/rst_n clock and async reset, clr clears word and count,
//        shift pushes din into the low byte, word/count are the results.
module loader_shift_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [2:0]  count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word  <= 32'd0;
      count <= 3'd0;
    end else if (clr) begin
      word  <= 32'd0;
      count <= 3'd0;
    end else if (shift) begin
      word  <= {word[23:0], din};
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses framed byte commands into IMEM/DMEM writes and CPU start.
// Latency: write strobe the cycle after the last payload byte; start_o the cycle after START.
// Backpressure: ready_o low during the WRITE cycle and forever once running.
// Ports: clk_i/rst_i clock and async active-low reset; byte_i/valid_i/ready_o
//        byte stream in; imem_* / dmem_* one-cycle write ports; start_o sticky
//        CPU start; err_o sticky protocol error.
// Option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to IWR/DWR frames.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    byte_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          imem_we_o,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr_o,
  output logic [31:0]                   imem_data_o,
  output logic                          dmem_we_o,
  output logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr_o,
  output logic [7:0]                    dmem_data_o,
  output logic                          start_o,
  output logic                          err_o
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [31:0] IMEM_LIM = 32'(IMEM_DEPTH);
  localparam logic [31:0] DMEM_LIM = 32'(DMEM_DEPTH);

  state_t          state_q, state_d;
  logic            ready_q;
  logic            accept;
  logic [7:0]      cmd_q;
  logic [7:0]      addr_q;
  logic            drop_q;
  logic            err_q;
  logic            asm_clr, asm_shift, last_byte;
  logic [31:0]     asm_word;
  logic [2:0]      asm_cnt;
  logic [IAW-1:0]  imem_addr_q;
  logic [31:0]     imem_data_q;
  logic [DAW-1:0]  dmem_addr_q;
  logic [7:0]      dmem_data_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      chk_q;
`endif

  // ready is registered from the next state so it is 0 while in reset.
  assign accept    = valid_i & ready_q;
  assign last_byte = (asm_cnt == ((cmd_q == CMD_IWR) ? IWR_LEN - 3'd1 : DWR_LEN - 3'd1));

  loader_shift_asm u_asm (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clr   (asm_clr),
    .shift (asm_shift),
    .din   (byte_i),
    .word  (asm_word),
    .count (asm_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    asm_clr   = 1'b0;
    asm_shift = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (byte_i == CMD_IWR || byte_i == CMD_DWR) state_d = ADDR;
        else if (byte_i == CMD_START)               state_d = RUN;
      end
      ADDR: if (accept) begin
        state_d = DATA;
        asm_clr = 1'b1;
      end
      DATA: if (accept) begin
        asm_shift = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (last_byte) state_d = CHK;
`else
        if (last_byte) state_d = WRITE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK:   if (accept) state_d = WRITE;
`endif
      WRITE: state_d = IDLE;
      RUN:   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_q     <= 1'b0;
      cmd_q       <= 8'd0;
      addr_q      <= 8'd0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= 32'd0;
      dmem_addr_q <= '0;
      dmem_data_q <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      chk_q       <= 8'd0;
`endif
    end else begin
      ready_q <= (state_d == IDLE) || (state_d == ADDR) ||
                 (state_d == DATA) || (state_d == CHK);
      if (accept && state_q == IDLE) begin
        cmd_q  <= byte_i;
        drop_q <= 1'b0;
        if (byte_i != CMD_IWR && byte_i != CMD_DWR && byte_i != CMD_START)
          err_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
        chk_q <= byte_i;
`endif
      end
      if (accept && state_q == ADDR) begin
        addr_q <= byte_i;
        // Out-of-range frames still consume their payload; only the write is dropped.
        if ((cmd_q == CMD_IWR && {24'd0, byte_i} >= IMEM_LIM) ||
            (cmd_q == CMD_DWR && {24'd0, byte_i} >= DMEM_LIM)) begin
          err_q  <= 1'b1;
          drop_q <= 1'b1;
        end
`ifdef LOADER_CHECKSUM_EN
        chk_q <= chk_q ^ byte_i;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      if (accept && state_q == DATA) chk_q <= chk_q ^ byte_i;
      if (accept && state_q == CHK && byte_i != chk_q) begin
        err_q  <= 1'b1;
        drop_q <= 1'b1;
      end
`endif
      // Capture what was written so the outputs hold it after the strobe.
      if (imem_we_o) begin
        imem_addr_q <= IAW'(addr_q);
        imem_data_q <= asm_word;
      end
      if (dmem_we_o) begin
        dmem_addr_q <= DAW'(addr_q);
        dmem_data_q <= asm_word[7:0];
      end
    end
  end

  assign imem_we_o   = (state_q == WRITE) && (cmd_q == CMD_IWR) && !drop_q;
  assign dmem_we_o   = (state_q == WRITE) && (cmd_q == CMD_DWR) && !drop_q;
  assign imem_addr_o = imem_we_o ? IAW'(addr_q) : imem_addr_q;
  assign imem_data_o = imem_we_o ? asm_word : imem_data_q;
  assign dmem_addr_o = dmem_we_o ? DAW'(addr_q) : dmem_addr_q;
  assign dmem_data_o = dmem_we_o ? asm_word[7:0] : dmem_data_q;
  assign ready_o     = ready_q;
  assign start_o     = (state_q == RUN);
  assign err_o       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader with a write scoreboard.
// Latency: checks strobe the cycle after the last byte and start_o after START.
// Backpressure: bytes are held until ready_o, bounded by a cycle budget.
module tb_prog_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  byte_i;
  logic        valid_i;
  logic        ready_o;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_data_o;
  logic        dmem_we_o;
  logic [4:0]  dmem_addr_o;
  logic [7:0]  dmem_data_o;
  logic        start_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_imem;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  prog_loader dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .byte_i      (byte_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_o (imem_data_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_addr_o (dmem_addr_o),
    .dmem_data_o (dmem_data_o),
    .start_o     (start_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk_i) begin
    wr_t e;
    if (rst_i === 1'b1 && (imem_we_o === 1'b1 || dmem_we_o === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {imem_we_o, dmem_we_o}, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_kind", {imem_we_o, dmem_we_o}, e.is_imem ? 2 : 1);
        if (e.is_imem) begin
          check("imem_addr", imem_addr_o, e.addr);
          check("imem_data", imem_data_o, e.data);
        end else begin
          check("dmem_addr", dmem_addr_o, e.addr[4:0]);
          check("dmem_data", dmem_data_o, e.data[7:0]);
        end
        check("wr_ready_low", ready_o, 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk_i);
    byte_i  = b;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) check("accept_timeout", n, 0);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  task automatic send_iwr(input logic [7:0] a, input logic [31:0] d);
    logic [7:0] x;
    x = 8'h01 ^ a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    send_byte(8'h01); send_byte(a);
    send_byte(d[31:24]); send_byte(d[23:16]); send_byte(d[15:8]); send_byte(d[7:0]);
`ifdef LOADER_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic send_dwr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] x;
    x = 8'h02 ^ a ^ d;
    send_byte(8'h02); send_byte(a); send_byte(d);
`ifdef LOADER_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic push_wr(input bit is_i, input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.is_imem = is_i; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; valid_i = 1'b1; byte_i = 8'h01;
    repeat (3) @(negedge clk_i);
    check("rst_ready", ready_o, 0);
    check("rst_imem_we", imem_we_o, 0);
    check("rst_imem_addr", imem_addr_o, 0);
    check("rst_imem_data", imem_data_o, 0);
    check("rst_dmem_we", dmem_we_o, 0);
    check("rst_dmem_addr", dmem_addr_o, 0);
    check("rst_dmem_data", dmem_data_o, 0);
    check("rst_start", start_o, 0);
    check("rst_err", err_o, 0);
    rst_i = 1'b1; valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("idle_ready", ready_o, 1);

    // IWR with latency and hold checks.
    push_wr(1, 8'h05, 32'h8C010004);
    send_iwr(8'h05, 32'h8C010004);
    @(negedge clk_i);
    check("iwr_strobe", imem_we_o, 1);
    check("iwr_ready", ready_o, 0);
    @(negedge clk_i);
    check("iwr_one_cycle", imem_we_o, 0);
    check("iwr_hold", imem_data_o, 32'h8C010004);
    check("iwr_ready_back", ready_o, 1);

    push_wr(0, 8'h00, 32'h05);
    send_dwr(8'h00, 8'h05);
    @(negedge clk_i);
    check("dwr_strobe", dmem_we_o, 1);

    // Out-of-range DWR: payload consumed, write dropped, loading continues.
    send_dwr(8'h20, 8'hAA);
    @(negedge clk_i);
    check("oor_no_we", dmem_we_o, 0);
    check("oor_err", err_o, 1);
    push_wr(1, 8'h00, 32'h00000001);
    send_iwr(8'h00, 32'h00000001);
    repeat (2) @(negedge clk_i);
    check("oor_err_sticky", err_o, 1);

    // Bad command, then reset in the middle of a frame.
    rst_i = 1'b0; #3 rst_i = 1'b1;
    check("rst_clears_err", err_o, 0);
    send_byte(8'h07);
    @(negedge clk_i);
    check("badcmd_err", err_o, 1);
    send_byte(8'h01); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    rst_i = 1'b0;
    #2;
    check("midrst_err", err_o, 0);
    check("midrst_ready", ready_o, 0);
    check("midrst_we", imem_we_o, 0);
    #2 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("midrst_no_write", exp_q.size(), 0);
    check("midrst_err_after", err_o, 0);

`ifdef LOADER_CHECKSUM_EN
    push_wr(0, 8'h01, 32'h7F);
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h7C);
    @(negedge clk_i);
    check("chk_ok_we", dmem_we_o, 1);
    check("chk_ok_err", err_o, 0);
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h00);
    @(negedge clk_i);
    check("chk_bad_we", dmem_we_o, 0);
    check("chk_bad_err", err_o, 1);
`endif

    push_wr(0, 8'h00, 32'h05);
    send_dwr(8'h00, 8'h05);
    repeat (2) @(negedge clk_i);
    send_byte(8'h03);
    @(negedge clk_i);
    check("start_rise", start_o, 1);
    check("run_ready", ready_o, 0);
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      byte_i = (i % 2 == 0) ? 8'h01 : 8'h02;
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    check("run_ignore_ready", ready_o, 0);
    check("run_start_sticky", start_o, 1);
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
